// File: rtl/regfile_wb_arbiter.sv
// Register file write-port owner: clears x1..x(NUM_REGS-1) after reset, then
// round-robin arbitrates ALU and LSU writeback requests onto a registered port.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32,
    parameter bit          CLEAR_EN = 1'b1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_wd,
    output logic              alu_ready,
    input  logic              lsu_valid,
    input  logic [ADDR_W-1:0] lsu_rd,
    input  logic [DATA_W-1:0] lsu_wd,
    output logic              lsu_ready,
    output logic              RegW,
    output logic [ADDR_W-1:0] Rd,
    output logic [DATA_W-1:0] Wd,
    output logic              init_done,
    output logic [CNT_W-1:0]  conflict_cnt
);

    typedef enum logic [0:0] {StClear, StRun} state_e;

    localparam logic [ADDR_W-1:0] LastIdx    = ADDR_W'(NUM_REGS - 1);
    localparam state_e            ResetState = CLEAR_EN ? StClear : StRun;

    state_e            state_q;
    logic [ADDR_W-1:0] sweep_q;
    logic              rr_q;      // 0: ALU wins next conflict, 1: LSU wins
    logic              conflict;

    // The port only opens once init_done is registered, so readies stay low
    // for the whole sweep including its final write cycle.
    always_comb begin
        conflict  = init_done && alu_valid && lsu_valid;
        alu_ready = init_done && alu_valid && (!lsu_valid || !rr_q);
        lsu_ready = init_done && lsu_valid && (!alu_valid || rr_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ResetState;
            sweep_q      <= ADDR_W'(1);
            rr_q         <= 1'b0;
            RegW         <= 1'b0;
            Rd           <= '0;
            Wd           <= '0;
            init_done    <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            RegW <= 1'b0;
            case (state_q)
                StClear: begin
                    RegW    <= 1'b1;
                    Rd      <= sweep_q;
                    Wd      <= '0;
                    sweep_q <= sweep_q + ADDR_W'(1);
                    if (sweep_q == LastIdx) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    init_done <= 1'b1;
                    // x0 writes are acknowledged but never reach the port.
                    if (alu_ready && (alu_rd != '0)) begin
                        RegW <= 1'b1;
                        Rd   <= alu_rd;
                        Wd   <= alu_wd;
                    end else if (lsu_ready && (lsu_rd != '0)) begin
                        RegW <= 1'b1;
                        Rd   <= lsu_rd;
                        Wd   <= lsu_wd;
                    end
                    if (conflict) begin
                        rr_q <= ~rr_q;
                        if (conflict_cnt != '1) begin
                            conflict_cnt <= conflict_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= ResetState;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: clear sweep, table-driven
// arbitration with a write scoreboard, reset abort and counter saturation.
module tb_regfile_wb_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        alu_valid, lsu_valid, alu_ready, lsu_ready;
    logic [4:0]  alu_rd, lsu_rd, Rd;
    logic [31:0] alu_wd, lsu_wd, Wd;
    logic        RegW, init_done;
    logic [15:0] conflict_cnt;

    // Second instance: no sweep, 4-bit counter for saturation.
    logic        rst2_n, v2, alu_ready2, lsu_ready2, RegW2, init_done2;
    logic [4:0]  rd2_a, rd2_l, Rd2;
    logic [31:0] wd2_a, wd2_l, Wd2;
    logic [3:0]  conflict_cnt2;

    regfile_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd), .lsu_ready(lsu_ready),
        .RegW(RegW), .Rd(Rd), .Wd(Wd), .init_done(init_done), .conflict_cnt(conflict_cnt)
    );

    regfile_wb_arbiter #(.CNT_W(4), .CLEAR_EN(1'b0)) dut2 (
        .clk(clk), .rst_n(rst2_n),
        .alu_valid(v2), .alu_rd(rd2_a), .alu_wd(wd2_a), .alu_ready(alu_ready2),
        .lsu_valid(v2), .lsu_rd(rd2_l), .lsu_wd(wd2_l), .lsu_ready(lsu_ready2),
        .RegW(RegW2), .Rd(Rd2), .Wd(Wd2), .init_done(init_done2),
        .conflict_cnt(conflict_cnt2)
    );

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] awd;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] lwd;
        logic        ear;
        logic        elr;
        logic [15:0] ecnt;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
    } exp_t;

    vec_t        vecs[14];
    exp_t        sbq[$];
    exp_t        e;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [4:0]  last_rd;
    logic [31:0] last_wd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //            av    ard    awd            lv    lrd    lwd           ear   elr   ecnt
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,       1'b1, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 1'b0, 16'd0};
        vecs[2]  = '{1'b1, 5'd3,  32'h1,        1'b1, 5'd4,  32'h2,       1'b1, 1'b0, 16'd0};
        vecs[3]  = '{1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h2,       1'b0, 1'b1, 16'd1};
        vecs[4]  = '{1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22,      1'b1, 1'b0, 16'd2};
        vecs[5]  = '{1'b1, 5'd3,  32'h111,      1'b1, 5'd4,  32'h22,      1'b0, 1'b1, 16'd3};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h5,       1'b0, 1'b1, 16'd4};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'hCAFE,    1'b0, 1'b1, 16'd4};
        vecs[8]  = '{1'b1, 5'd8,  32'hA8,       1'b1, 5'd9,  32'hB9,      1'b1, 1'b0, 16'd4};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'hB9,      1'b0, 1'b1, 16'd5};
        vecs[10] = '{1'b1, 5'd10, 32'hA10,      1'b1, 5'd11, 32'hB11,     1'b0, 1'b1, 16'd5};
        vecs[11] = '{1'b1, 5'd10, 32'hA10,      1'b1, 5'd12, 32'hB12,     1'b1, 1'b0, 16'd6};
        vecs[12] = '{1'b1, 5'd0,  32'hFF,       1'b0, 5'd0,  32'h0,       1'b1, 1'b0, 16'd7};
        vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 1'b0, 16'd7};

        rst_n = 1'b0; rst2_n = 1'b0; v2 = 1'b0;
        rd2_a = 5'd6; wd2_a = 32'h66; rd2_l = 5'd7; wd2_l = 32'h77;
        // Valids held high during the sweep to prove readies stay low.
        alu_valid = 1'b1; alu_rd = 5'd2; alu_wd = 32'h12;
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_wd = 32'h13;

        #1;
        chk("rst_regw", 64'(RegW), 64'd0);
        chk("rst_rd", 64'(Rd), 64'd0);
        chk("rst_wd", 64'(Wd), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_cnt", 64'(conflict_cnt), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        for (int k = 1; k <= 31; k++) begin
            @(posedge clk); #1;
            chk("sweep_regw", 64'(RegW), 64'd1);
            chk("sweep_rd", 64'(Rd), 64'(k));
            chk("sweep_wd", 64'(Wd), 64'd0);
            chk("sweep_init_done", 64'(init_done), 64'd0);
            chk("sweep_readies", 64'({alu_ready, lsu_ready}), 64'd0);
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        @(posedge clk); #1;
        chk("init_done_set", 64'(init_done), 64'd1);
        chk("post_sweep_regw", 64'(RegW), 64'd0);
        chk("post_sweep_cnt", 64'(conflict_cnt), 64'd0);
        last_rd = 5'd31;
        last_wd = 32'h0;

        for (int i = 0; i < 14; i++) begin
            alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_wd = vecs[i].awd;
            lsu_valid = vecs[i].lv; lsu_rd = vecs[i].lrd; lsu_wd = vecs[i].lwd;
            @(negedge clk);
            chk($sformatf("row%0d_alu_ready", i), 64'(alu_ready), 64'(vecs[i].ear));
            chk($sformatf("row%0d_lsu_ready", i), 64'(lsu_ready), 64'(vecs[i].elr));
            chk($sformatf("row%0d_cnt", i), 64'(conflict_cnt), 64'(vecs[i].ecnt));
            if (vecs[i].ear && vecs[i].ard != 5'd0)
                sbq.push_back('{1'b1, vecs[i].ard, vecs[i].awd});
            else if (vecs[i].elr && vecs[i].lrd != 5'd0)
                sbq.push_back('{1'b1, vecs[i].lrd, vecs[i].lwd});
            else
                sbq.push_back('{1'b0, 5'd0, 32'h0});
            @(posedge clk); #1;
            if (sbq.size() == 0) begin
                chk("scoreboard_empty", 64'd1, 64'd0);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("row%0d_regw", i), 64'(RegW), 64'(e.we));
                if (e.we) begin
                    last_rd = e.rd;
                    last_wd = e.wd;
                end
                chk($sformatf("row%0d_rd", i), 64'(Rd), 64'(last_rd));
                chk($sformatf("row%0d_wd", i), 64'(Wd), 64'(last_wd));
            end
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;

        // Saturation on the 4-bit instance.
        rst2_n = 1'b1;
        @(posedge clk); #1;
        chk("dut2_init_done", 64'(init_done2), 64'd1);
        v2 = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            chk($sformatf("sat_cnt_%0d", n), 64'(conflict_cnt2), 64'((n > 15) ? 15 : n));
        end
        v2 = 1'b0;

        // Reset abort mid-sweep.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            chk("resweep_rd", 64'(Rd), 64'(k));
        end
        rst_n = 1'b0;
        #1;
        chk("abort_regw", 64'(RegW), 64'd0);
        chk("abort_rd", 64'(Rd), 64'd0);
        chk("abort_init_done", 64'(init_done), 64'd0);
        @(posedge clk); #1;
        chk("held_rst_regw", 64'(RegW), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("restart_regw", 64'(RegW), 64'd1);
        chk("restart_rd", 64'(Rd), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
